// File: rtl/gamma_expand_pkg.sv
// Shared types and defaults for the gamma expansion LUT pipeline.
package gamma_expand_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gamma_lut_ram.sv
// 2^DATA_W x DATA_W lookup RAM: one synchronous write port, one registered read port.
module gamma_lut_ram #(
  parameter int DATA_W = 8
) (
  input  logic              iCLK,
  input  logic              we,
  input  logic [DATA_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [DATA_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**DATA_W];

  // No reset on purpose: the owner fills the array after reset.
  always_ff @(posedge iCLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/gamma_expand.sv
// Gamma expansion: fills a LUT after reset, then streams pixels through a
// two-stage (RAM read, output register) valid/ready pipeline.
module gamma_expand
  import gamma_expand_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter bit INIT_IDENTITY = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] signal_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] result,
  input  logic              cfg_we,
  input  logic [DATA_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              init_done
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              s1_valid;
  logic              advance;
  logic              take;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // In INIT the fill counter owns the write port and config writes are dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = cfg_addr;
    ram_wdata = cfg_data;
    init_done = 1'b0;
    ready_out = 1'b0;
    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = INIT_IDENTITY ? cnt_q : '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        init_done = 1'b1;
        ram_we    = cfg_we;
        ready_out = !cfg_we && advance;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign advance = !valid_out || ready_in;
  assign take    = valid_in && ready_out;

  // Read only on acceptance so the registered RAM output doubles as stage-1 data hold.
  gamma_lut_ram #(
    .DATA_W(DATA_W)
  ) u_lut (
    .iCLK (iCLK),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (take),
    .raddr(signal_in),
    .rdata(ram_rdata)
  );

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      s1_valid  <= 1'b0;
      valid_out <= 1'b0;
      result    <= '0;
    end else if (advance) begin
      s1_valid  <= take;
      valid_out <= s1_valid;
      if (s1_valid) begin
        result <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_gamma_expand.sv
// Randomized self-checking bench for gamma_expand against an array/queue LUT model.
module tb_gamma_expand;

  logic       iCLK;
  logic       iRESET;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] signal_in;
  logic       valid_out;
  logic       ready_in;
  logic [7:0] result;
  logic       cfg_we;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       init_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] lut_model [256];
  logic [7:0] exp_q [$];
  int         acc_q [$];
  logic       model_run  = 1'b0;
  logic       check_lat  = 1'b0;
  logic [7:0] last_result = 8'h00;

  gamma_expand #(
    .DATA_W       (8),
    .INIT_IDENTITY(1'b1)
  ) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .signal_in(signal_in),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .result   (result),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .init_done(init_done)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check handshakes and outputs, advance the model.
  task automatic applyStimulus(input logic v, input logic [7:0] s, input logic rdy,
                               input logic we, input logic [7:0] a, input logic [7:0] d,
                               output logic acc);
    logic [7:0] exp_val;
    int         acc_cyc;
    valid_in  = v;
    signal_in = s;
    ready_in  = rdy;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_data  = d;
    #1;
    checkOutput("ready_out", {31'd0, ready_out},
                {31'd0, model_run && !we && (!valid_out || rdy)});
    if (!valid_out) begin
      checkOutput("result_hold", {24'd0, result}, {24'd0, last_result});
    end
    if (valid_out && rdy) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out", 32'd1, 32'd0);
      end else begin
        exp_val = exp_q.pop_front();
        acc_cyc = acc_q.pop_front();
        checkOutput("result", {24'd0, result}, {24'd0, exp_val});
        last_result = exp_val;
        if (check_lat) begin
          checkOutput("latency", cyc - acc_cyc, 32'd2);
        end
      end
    end
    acc = v && ready_out;
    if (acc) begin
      exp_q.push_back(lut_model[s]);
      acc_q.push_back(cyc);
    end
    if (we && model_run) begin
      lut_model[a] = d;
    end
    @(negedge iCLK);
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    int   guard;
    guard = 0;
    while ((exp_q.size() != 0 || valid_out) && guard < 50) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, acc);
      guard++;
    end
    checkOutput("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic applyReset(input logic we_during_init);
    int cycles;
    int bad;
    iRESET   = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b1;
    cfg_we   = 1'b0;
    @(negedge iCLK);
    checkOutput("rst_valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("rst_result", {24'd0, result}, 32'd0);
    checkOutput("rst_ready_out", {31'd0, ready_out}, 32'd0);
    checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    model_run   = 1'b0;
    last_result = 8'h00;
    iRESET    = 1'b0;
    cfg_we    = we_during_init;
    cfg_addr  = 8'd5;
    cfg_data  = 8'd77;
    valid_in  = 1'b1;
    signal_in = 8'd3;
    cycles = 0;
    bad    = 0;
    while (!init_done && cycles < 1000) begin
      if (ready_out || valid_out) bad++;
      @(negedge iCLK);
      cycles++;
    end
    checkOutput("init_cycles", cycles, 32'd256);
    checkOutput("init_quiet", bad, 32'd0);
    cfg_we   = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < 256; i++) lut_model[i] = 8'(i);
    model_run = 1'b1;
  endtask

  initial begin
    logic acc;
    int   idx;
    int   guard;
    iRESET    = 1'b1;
    valid_in  = 1'b0;
    signal_in = 8'h00;
    ready_in  = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 8'h00;
    cfg_data  = 8'h00;
    repeat (2) @(negedge iCLK);

    $display("[TB] reset and identity fill");
    applyReset(1'b0);

    $display("[TB] identity stream, full throughput");
    check_lat = 1'b1;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 8'h00, 8'h00, acc);
      checkOutput("stream_accept", {31'd0, acc}, 32'd1);
    end
    drain();
    check_lat = 1'b0;

    $display("[TB] write ordering around LUT[90]");
    applyStimulus(1'b1, 8'd90, 1'b1, 1'b0, 8'h00, 8'h00, acc);
    applyStimulus(1'b1, 8'd90, 1'b1, 1'b1, 8'd90, 8'd128, acc);
    checkOutput("write_blocks", {31'd0, acc}, 32'd0);
    applyStimulus(1'b1, 8'd90, 1'b1, 1'b0, 8'h00, 8'h00, acc);
    checkOutput("lut90_model", {24'd0, lut_model[90]}, 32'd128);
    drain();

    $display("[TB] back-to-back writes to one address");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'd17, 8'd33, acc);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'd17, 8'd200, acc);
    applyStimulus(1'b1, 8'd17, 1'b1, 1'b0, 8'h00, 8'h00, acc);
    drain();

    $display("[TB] inverted LUT, random backpressure");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'(i), 8'(i) ^ 8'hFF, acc);
    end
    idx   = 0;
    guard = 0;
    while (idx < 256 && guard < 5000) begin
      applyStimulus(($urandom_range(0, 3) != 0), 8'(idx), 1'($urandom_range(0, 1)),
                    1'b0, 8'h00, 8'h00, acc);
      if (acc) idx++;
      guard++;
    end
    checkOutput("random_all_sent", idx, 32'd256);
    drain();

    $display("[TB] writes interleaved with streaming");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'(i % 2),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), acc);
      checkOutput("interleave_accept", {31'd0, acc}, {31'd0, !(1'(i % 2))});
    end
    drain();

    $display("[TB] reset with pixels in flight");
    applyStimulus(1'b1, 8'd40, 1'b1, 1'b0, 8'h00, 8'h00, acc);
    applyStimulus(1'b1, 8'd41, 1'b1, 1'b0, 8'h00, 8'h00, acc);
    applyReset(1'b1);
    check_lat = 1'b1;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(255 - i), 1'b1, 1'b0, 8'h00, 8'h00, acc);
    end
    drain();
    check_lat = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
